// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment bus reader: normalised (active-high,
// abcdefg) segment patterns, the capture FSM state type and the pattern decoder.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Returns {err, blank, nibble[3:0]}; blank and unknown patterns yield nibble 0.
  function automatic logic [5:0] seg_to_nibble(input logic [6:0] seg);
    logic [5:0] res;
    case (seg)
      SEG_0:     res = {2'b00, 4'h0};
      SEG_1:     res = {2'b00, 4'h1};
      SEG_2:     res = {2'b00, 4'h2};
      SEG_3:     res = {2'b00, 4'h3};
      SEG_4:     res = {2'b00, 4'h4};
      SEG_5:     res = {2'b00, 4'h5};
      SEG_6:     res = {2'b00, 4'h6};
      SEG_7:     res = {2'b00, 4'h7};
      SEG_8:     res = {2'b00, 4'h8};
      SEG_9:     res = {2'b00, 4'h9};
      SEG_A:     res = {2'b00, 4'hA};
      SEG_B:     res = {2'b00, 4'hB};
      SEG_C:     res = {2'b00, 4'hC};
      SEG_D:     res = {2'b00, 4'hD};
      SEG_E:     res = {2'b00, 4'hE};
      SEG_F:     res = {2'b00, 4'hF};
      SEG_BLANK: res = {2'b01, 4'h0};
      default:   res = {2'b10, 4'h0};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seven_seg_encoder.sv
// Combinational recovery of a hex nibble from one normalised segment pattern,
// flagging blank digits and patterns that are not a hex glyph.
module seven_seg_encoder
  import seven_seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_blank,
  output logic       o_err
);

  logic [5:0] w_dec;

  assign w_dec                        = seg_to_nibble(i_seg);
  assign {o_err, o_blank, o_nibble}   = w_dec;

endmodule

// File: rtl/seven_seg_reader.sv
// Reads back a multiplexed seven-segment display bus and assembles one word per
// frame of NUM_DIGITS digits. Define SEVEN_SEG_READER_DP_EN to also track decimal points.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int COMMON_ANODE   = 1,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int SETTLE_CYCLES  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
`ifdef SEVEN_SEG_READER_DP_EN
  input  logic                    seg_dp,
  output logic [NUM_DIGITS-1:0]   dp_mask,
`endif
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    frame_valid
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [IDX_W-1:0]        r_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [7:0]              r_pat_prev;
  logic [NUM_DIGITS-1:0]   r_seen;
  logic [4*NUM_DIGITS-1:0] r_hold_val;
  logic [NUM_DIGITS-1:0]   r_hold_blank;
  logic [NUM_DIGITS-1:0]   r_hold_err;

  logic [6:0]              w_seg;
  logic [7:0]              w_pat;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_onehot;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_same_idx;
  logic                    w_pat_changed;
  logic                    w_latch;
  logic                    w_capture;
  logic                    w_frame_done;
  logic [NUM_DIGITS-1:0]   w_seen_next;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  logic                    w_err;

  assign w_seg = (COMMON_ANODE != 0)   ? ~seg_in  : seg_in;
  assign w_sel = (DIG_ACTIVE_LOW != 0) ? ~dig_sel : dig_sel;

`ifdef SEVEN_SEG_READER_DP_EN
  logic                  w_dp;
  logic [NUM_DIGITS-1:0] r_hold_dp;

  assign w_dp  = (COMMON_ANODE != 0) ? ~seg_dp : seg_dp;
  assign w_pat = {w_dp, w_seg};
`else
  // The top bit of the stability pattern is the decimal point; tie it off here.
  assign w_pat = {1'b0, w_seg};
`endif

  assign w_onehot      = (w_sel != '0) &&
                         ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
  assign w_same_idx    = w_onehot && (w_idx == r_idx);
  assign w_pat_changed = (w_pat != r_pat_prev);

  // Position of the selected digit; only meaningful when the selection is one-hot.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_idx = w_idx | (w_sel[i] ? IDX_W'(i) : '0);
    end
  end

  // The settled pattern is taken from the previous-cycle register so CAPTURE
  // decodes exactly what was checked for stability.
  seven_seg_encoder u_encoder (
    .i_seg    (r_pat_prev[6:0]),
    .o_nibble (w_nibble),
    .o_blank  (w_blank),
    .o_err    (w_err)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_next = SETTLE;
        end else begin
          w_state_next = IDLE;
        end
      end
      SETTLE: begin
        if (!w_same_idx) begin
          w_state_next = IDLE;
        end else if (w_pat_changed) begin
          w_state_next = SETTLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_next = CAPTURE;
        end else begin
          w_state_next = SETTLE;
        end
      end
      CAPTURE: w_state_next = HOLD;
      HOLD: begin
        if (w_same_idx) begin
          w_state_next = HOLD;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: index latch and capture strobe.
  always_comb begin
    w_latch   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE:    w_latch   = w_onehot;
      CAPTURE: w_capture = 1'b1;
      default: begin
        w_latch   = 1'b0;
        w_capture = 1'b0;
      end
    endcase
  end

  // Selected index, settle counter (saturating) and previous-cycle pattern.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx      <= '0;
      r_cnt      <= '0;
      r_pat_prev <= '0;
    end else begin
      r_pat_prev <= w_pat;
      if (w_latch) begin
        r_idx <= w_idx;
        r_cnt <= '0;
      end else if (r_state == SETTLE) begin
        if (w_pat_changed) begin
          r_cnt <= '0;
        end else if (r_cnt != CNT_MAX) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end else begin
          r_cnt <= r_cnt;
        end
      end else begin
        r_idx <= r_idx;
        r_cnt <= r_cnt;
      end
    end
  end

  // A capture in the completion cycle is OR-ed in after the clear, so it opens the next frame.
  assign w_frame_done = (r_seen == '1);
  assign w_seen_next  = (w_frame_done ? '0 : r_seen) |
                        (w_capture ? (NUM_DIGITS'(1) << r_idx) : '0);

  // Per-digit holding registers and the seen vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen       <= '0;
      r_hold_val   <= '0;
      r_hold_blank <= '0;
      r_hold_err   <= '0;
`ifdef SEVEN_SEG_READER_DP_EN
      r_hold_dp    <= '0;
`endif
    end else begin
      r_seen <= w_seen_next;
      if (w_capture) begin
        r_hold_val[{r_idx, 2'b00} +: 4] <= w_nibble;
        r_hold_blank[r_idx]             <= w_blank;
        r_hold_err[r_idx]               <= w_err;
`ifdef SEVEN_SEG_READER_DP_EN
        r_hold_dp[r_idx]                <= r_pat_prev[7];
`endif
      end
    end
  end

  // Frame publication; outputs keep their value between frames.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid <= 1'b0;
      value_out   <= '0;
      blank_mask  <= '0;
      err_mask    <= '0;
`ifdef SEVEN_SEG_READER_DP_EN
      dp_mask     <= '0;
`endif
    end else begin
      frame_valid <= w_frame_done;
      if (w_frame_done) begin
        value_out  <= r_hold_val;
        blank_mask <= r_hold_blank;
        err_mask   <= r_hold_err;
`ifdef SEVEN_SEG_READER_DP_EN
        dp_mask    <= r_hold_dp;
`endif
      end
    end
  end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
- Captures a multiplexed 7-segment display bus (segments a–g plus digit-select lines) and recovers each displayed hex digit as a 4-bit nibble.
- Inverse direction of the team's binary-to-segment decoder.
- Used to read back our own display drive, or an external board's display, for self-test and monitoring.
- Assembles NUM_DIGITS nibbles into one word and emits a one-cycle frame strobe when every digit has been captured.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥2); width of dig_sel, blank_mask and err_mask.
- COMMON_ANODE, 1, 1 = segment inputs are active-low; 0 = active-high.
- DIG_ACTIVE_LOW, 1, 1 = dig_sel bits are active-low.
- SETTLE_CYCLES, 8, consecutive cycles seg_in must be unchanged under a stable one-hot selection before it is captured (≥1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- seg_in  in  7  segment lines, bit6 = a … bit0 = g; polarity per COMMON_ANODE.
- dig_sel  in  NUM_DIGITS  digit-select lines; bit i selects digit i; polarity per DIG_ACTIVE_LOW.
- value_out  out  4*NUM_DIGITS  captured nibbles; digit i in bits [4i+3:4i].
- blank_mask  out  NUM_DIGITS  bit i set = digit i was blank (all segments off).
- err_mask  out  NUM_DIGITS  bit i set = digit i held an unrecognised pattern.
- frame_valid  out  1  one-cycle pulse; value_out, blank_mask and err_mask are valid in that cycle.

Behaviour:
- Input normalisation is combinational.
  - seg_in is inverted when COMMON_ANODE = 1; dig_sel is inverted when DIG_ACTIVE_LOW = 1.
  - "onehot" means exactly one normalised dig_sel bit is set; idx is its position.
- Pattern mapping (normalised, abcdefg):
  - 0 = 1111110, 1 = 0110000, 2 = 1101101, 3 = 1111001, 4 = 0110011
  - 5 = 1011011, 6 = 1011111, 7 = 1110000, 8 = 1111111, 9 = 1111011
  - A = 1110111, b = 0011111, C = 1001110, d = 0111101, E = 1001111, F = 1000111
  - 0000000 = blank: nibble 0, blank bit set.
  - Any other pattern: nibble 0, err bit set.
- FSM states and transitions:
  - IDLE: wait for onehot; latch idx, clear cnt → SETTLE.
  - SETTLE:
    - If not onehot, or the index differs from the latched idx: → IDLE, nothing captured.
    - Else if seg_in differs from the previous cycle: cnt ← 0.
    - Else cnt increments; when cnt reaches SETTLE_CYCLES−1 → CAPTURE.
  - CAPTURE (exactly 1 cycle):
    - Write nibble, blank and err bits for digit idx into the holding registers.
    - Set seen[idx] → HOLD.
  - HOLD: stay while the selection equals the latched idx; otherwise → IDLE. Each select pulse gives at most one capture.
- Capture latency: the CAPTURE cycle is SETTLE_CYCLES+1 cycles after the first cycle in which the selection and segments are both stable.
- Frame completion:
  - The cycle after seen becomes all-ones, the holding registers are copied to value_out, blank_mask and err_mask.
  - frame_valid is high for that one cycle; seen is cleared in the same cycle.
  - Outputs hold their values between frames.
- Same digit captured twice before the frame completes: the later capture overwrites the earlier one; no error.
- A capture in the same cycle as frame completion belongs to the next frame; its seen bit is set after the clear.
- Reset, including mid-frame:
  - FSM → IDLE; cnt and seen cleared; holding registers cleared; partial frame discarded.
  - value_out, blank_mask, err_mask = 0; frame_valid = 0.
- cnt width is $clog2(SETTLE_CYCLES+1); cnt saturates and never wraps.

Optional Feature:
- Macro: SEVEN_SEG_READER_DP_EN.
- Defined:
  - Adds input seg_dp (1 bit, same polarity as seg_in) and output dp_mask (NUM_DIGITS bits).
  - seg_dp is included in the SETTLE stability check, captured per digit in CAPTURE, and published with the frame.
  - dp_mask resets to 0.
- Undefined: neither port exists; the decimal point is ignored.

Decomposition:
- Package seven_seg_pkg holds:
  - Normalised pattern constants SEG_0…SEG_F and SEG_BLANK.
  - The FSM state enum (IDLE, SETTLE, CAPTURE, HOLD).
  - Pure function seg_to_nibble returning {err, blank, nibble[3:0]}.
- One sub-module, seven_seg_encoder: combinational pattern → nibble/blank/err, built on the package function.
- seven_seg_reader contains the FSM, counters and frame assembly.

Test Plan:
- Normal frame: COMMON_ANODE = 1, DIG_ACTIVE_LOW = 1, scan digits 0..3 showing patterns for 1, 2, A, F, 20 cycles each → one frame_valid pulse; value_out = 0xFA21, blank_mask = 0, err_mask = 0.
- Glitch restarts settle: SETTLE_CYCLES = 8, seg_in toggles on cycle 5 of a select pulse, then stays on "7" for 8 cycles → exactly one capture of 7, occurring 9 cycles after the toggle.
- Short pulse: select held only 6 cycles → no capture; seen unchanged; no frame_valid.
- Blank and error: digit 3 blank, digit 2 pattern 0101010 (normalised) → blank_mask = 0b1000, err_mask = 0b0100, nibbles 3 and 2 = 0.
- Multi-select and reset: dig_sel with two active bits → stays IDLE. Reset asserted after 2 of 4 digits captured → all outputs 0; the following full scan yields exactly one frame.
- Back-to-back frames: two consecutive scans with different values → two frame_valid pulses with correct values; the capture coinciding with the frame pulse lands in frame 2.
